fifo_rd_stream_adapter: RTL

- Read-side consumer stage for the asynchronous FIFO. Sits directly downstream of the FIFO read-clock pointer/empty logic and the memory read port, in the r_clk domain.
- Decides when to pulse r_en, tracks reads in flight through the RD_LAT-cycle memory read path, and captures the returned words into a small output buffer.
- Presents the captured words as a valid/ready stream to the downstream logic, with full throughput and no overrun.

---
 rtl/fifo_rd_stream_adapter_if.sv | 23 ++
 rtl/fifo_rd_stream_adapter.sv | 98 +++++++++
 2 files changed

// File: rtl/fifo_rd_stream_adapter_if.sv
// Handshake bundle between the FIFO read port, the read adapter and the downstream stream.
// Modport master is the adapter's view; modport slave is the surrounding logic's view.
interface fifo_rd_stream_adapter_if #(
  parameter int DATA_SIZE = 8
);
  logic                 r_empty;
  logic                 r_en;
  logic [DATA_SIZE-1:0] r_data;
  logic                 flush;
  logic                 m_valid;
  logic                 m_ready;
  logic [DATA_SIZE-1:0] m_data;

  modport master (
    input  r_empty, r_data, flush, m_ready,
    output r_en, m_valid, m_data
  );

  modport slave (
    output r_empty, r_data, flush, m_ready,
    input  r_en, m_valid, m_data
  );
endinterface

// File: rtl/fifo_rd_stream_adapter.sv
// Read-side consumer for the async FIFO: issues r_en, tracks the RD_LAT read pipeline and
// buffers returned words into a valid/ready stream. Define RD_ADAPTER_STALL_CNT_EN for stall_cnt.
module fifo_rd_stream_adapter #(
  parameter int DATA_SIZE = 8,
  parameter int RD_LAT    = 1,
  parameter int OUT_DEPTH = 2
) (
  input  logic                     r_clk,
  input  logic                     rrst_n,
  fifo_rd_stream_adapter_if.master bus
`ifdef RD_ADAPTER_STALL_CNT_EN
  ,
  output logic [15:0]              stall_cnt
`endif
);
  localparam int PW = $clog2(OUT_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = CW + 3;

  logic [DATA_SIZE-1:0] mem_q [OUT_DEPTH];
  logic [DATA_SIZE-1:0] mem_d [OUT_DEPTH];
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [RD_LAT-1:0]    vld_q, vld_d;
  logic [SW-1:0]        inflight;
  logic [SW-1:0]        pending;
  logic                 push;
  logic                 pop;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + SW'(vld_q[i]);
  end

  assign push = vld_q[RD_LAT-1];
  assign pop  = bus.m_valid & bus.m_ready;

  // Slots freed by this cycle's pop can be reissued immediately, which keeps one word per cycle.
  assign pending     = SW'(count_q) + inflight - SW'(pop);
  assign bus.r_en    = rrst_n & ~bus.r_empty & ~bus.flush & (pending < SW'(OUT_DEPTH));
  assign bus.m_valid = (count_q != '0);
  assign bus.m_data  = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    vld_d    = RD_LAT'({vld_q, bus.r_en});
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      vld_d    = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = bus.r_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge r_clk or negedge rrst_n) begin
    if (!rrst_n) begin
      for (int i = 0; i < OUT_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      vld_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      vld_q    <= vld_d;
    end
  end

`ifdef RD_ADAPTER_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (bus.flush)                                           stall_d = '0;
    else if (bus.m_valid && !bus.m_ready && stall_q != '1)   stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge r_clk or negedge rrst_n) begin
    if (!rrst_n) stall_q <= '0;
    else         stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`endif
endmodule
